// File: rtl/cpu_pkg.sv
// cpu_pkg: shared width, reset PC and fetch FSM encodings for the PC stage.
package cpu_pkg;
    localparam int DEF_XLEN = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: prioritised next-PC target selection and alignment check.
import cpu_pkg::*;
module next_pc_calc #(
    parameter int XLEN = DEF_XLEN
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            Jal,
    input  logic            Jalr,
    input  logic            Branch_jump,
    output logic [XLEN-1:0] target,
    output logic            target_misaligned
);
    logic [XLEN-1:0] jalr_sum;
    always_comb begin
        jalr_sum = rs1_data + imm;
        target = Jalr ? {jalr_sum[XLEN-1:1], 1'b0} :
                 (Jal || Branch_jump) ? pc + imm : pc + XLEN'(4);
        // bit0 is always clear here (jalr masks it, pc/imm are even), so bit1 decides
        target_misaligned = target[1];
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, req/ack fetch FSM and misaligned-target halt.
import cpu_pkg::*;
module pc_fetch_unit #(
    parameter int              XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Branch_jump,
    input  logic            Jal,
    input  logic            Jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            inst_valid,
    output logic            misalign
);
    state_t          state, state_next;
    logic [XLEN-1:0] target;
    logic            target_misaligned;

    next_pc_calc #(.XLEN(XLEN)) u_next_pc (
        .pc(pc),
        .imm(imm),
        .rs1_data(rs1_data),
        .Jal(Jal),
        .Jalr(Jalr),
        .Branch_jump(Branch_jump),
        .target(target),
        .target_misaligned(target_misaligned)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            misalign <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_EXEC && !stall) begin
                if (target_misaligned) misalign <= 1'b1;
                else pc <= target;
            end
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        case (state)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_next = S_EXEC;
            end
            S_EXEC:  begin
                inst_valid = 1'b1;
                if (!stall) state_next = target_misaligned ? S_HALT : S_FETCH;
            end
            default: state_next = S_HALT;
        endcase
    end

    assign imem_addr = pc;
    assign pc_plus4  = pc + XLEN'(4);
endmodule
